// File: rtl/tt_bist_harness_if.sv
// DUT-facing bus of the BIST harness: the Tiny Tapeout user-project pins.
// The harness takes the master side, the wrapped project the slave side.
interface tt_bist_harness_if #(
  parameter int IN_W  = 8,
  parameter int IO_W  = 8,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  dut_ui;
  logic [IO_W-1:0]  dut_uio_in;
  logic             dut_ena;
  logic             dut_rst_n;
  logic [OUT_W-1:0] dut_uo;
  logic [IO_W-1:0]  dut_uio_out;
  logic [IO_W-1:0]  dut_uio_oe;

  modport master (
    output dut_ui, dut_uio_in, dut_ena, dut_rst_n,
    input  dut_uo, dut_uio_out, dut_uio_oe
  );

  modport slave (
    input  dut_ui, dut_uio_in, dut_ena, dut_rst_n,
    output dut_uo, dut_uio_out, dut_uio_oe
  );
endinterface

// File: rtl/tt_bist_harness.sv
// Stimulus/capture harness for a Tiny Tapeout-style user project.
// Holds the project in reset, then drives LFSR inputs for len cycles while
// folding every output into a MISR signature, so one compare checks a run.
module tt_bist_harness #(
  parameter int                IN_W       = 8,
  parameter int                IO_W       = 8,
  parameter int                OUT_W      = 8,
  parameter int                MISR_W     = 32,
  parameter logic [MISR_W-1:0] MISR_POLY  = 32'h04C11DB7,
  parameter int                LEN_W      = 16,
  parameter int                RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      len,
  input  logic [15:0]           seed,
  tt_bist_harness_if.master     dut,
  output logic                  busy,
  output logic                  done,
  output logic [MISR_W-1:0]     signature,
  output logic [LEN_W-1:0]      cycle_count
);

  localparam int          CAP_W     = OUT_W + 2 * IO_W;
  localparam int          RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [15:0] SEED_DFLT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [LEN_W-1:0]  len_q;
  logic [RC_W-1:0]   rst_cnt;
  logic              ena_q;
  logic              rst_n_q;
  logic              run_st;
  logic [LEN_W-1:0]  cc_inc;
  logic [CAP_W-1:0]  capture;

  // Galois right-shift LFSR step
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // MISR step: shift with polynomial feedback, then fold in the captured outputs
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [CAP_W-1:0]  d);
    return (s << 1) ^ (s[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(d);
  endfunction

  assign run_st  = (state == S_RUN);
  assign cc_inc  = cycle_count + LEN_W'(1);
  assign capture = {dut.dut_uio_oe, dut.dut_uio_out, dut.dut_uo};

  // Stimulus only leaves the harness in RUN; pins the DUT drives read back as 0
  assign dut.dut_ui     = run_st ? lfsr[IN_W-1:0] : '0;
  assign dut.dut_uio_in = run_st ? (lfsr[IN_W+IO_W-1:IN_W] & ~dut.dut_uio_oe) : '0;
  assign dut.dut_ena    = ena_q;
  assign dut.dut_rst_n  = rst_n_q;

  // Sequencer FSM with registered control outputs, LFSR, MISR and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ena_q       <= 1'b0;
      rst_n_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signature   <= '0;
      cycle_count <= '0;
      lfsr        <= SEED_DFLT;
      len_q       <= '0;
      rst_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q       <= len;
            lfsr        <= (seed == 16'h0000) ? SEED_DFLT : seed;
            signature   <= '0;
            cycle_count <= '0;
            rst_cnt     <= '0;
            state       <= S_RESET;
            ena_q       <= 1'b1;
            rst_n_q     <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        S_RESET: begin
          if (abort) begin
            state   <= S_IDLE;
            ena_q   <= 1'b0;
            rst_n_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            rst_n_q <= 1'b1;
            if (len_q != '0) begin
              state <= S_RUN;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            ena_q   <= 1'b0;
            rst_n_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else begin
            lfsr        <= lfsr_next(lfsr);
            signature   <= misr_next(signature, capture);
            cycle_count <= cc_inc;
            if (cc_inc == len_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ena_q   <= 1'b0;
          rst_n_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed self-checking bench for tt_bist_harness.
module tb_tt_bist_harness;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] len;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [15:0] cycle_count;

  int n_pass  = 0;
  int n_total = 0;

  int         n_rst;
  int         n_run;
  logic       got_done;
  logic       first_done;
  logic       first_busy;
  logic       found;
  logic [7:0] ui_log  [8];
  logic [7:0] uio_log [8];

  tt_bist_harness_if bus ();

  tt_bist_harness u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .len         (len),
    .seed        (seed),
    .dut         (bus),
    .busy        (busy),
    .done        (done),
    .signature   (signature),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start a test and observe it cycle by cycle until done or budget expires
  task automatic run_obs(input logic [15:0] l, input logic [15:0] s, input int pulse_at);
    n_rst    = 0;
    n_run    = 0;
    got_done = 1'b0;
    len      = l;
    seed     = s;
    start    = 1'b1;
    tick();
    start      = 1'b0;
    first_done = done;
    first_busy = busy;
    for (int i = 0; i < 200; i++) begin
      start = (i == pulse_at);
      if (bus.dut_ena && !bus.dut_rst_n) n_rst++;
      if (busy && bus.dut_rst_n) begin
        if (n_run < 8) begin
          ui_log[n_run]  = bus.dut_ui;
          uio_log[n_run] = bus.dut_uio_in;
        end
        n_run++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    chk("run_reached_done", got_done, 1'b1);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    len             = '0;
    seed            = '0;
    bus.dut_uo      = '0;
    bus.dut_uio_out = '0;
    bus.dut_uio_oe  = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_ena", bus.dut_ena, 0);
    chk("rst_rst_n", bus.dut_rst_n, 0);
    chk("rst_ui", bus.dut_ui, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Seed 0 -> ACE1, len 4, outputs tied low
    run_obs(16'd4, 16'h0000, -1);
    chk("t1_first_busy", first_busy, 1);
    chk("t1_rst_cycles", n_rst, 4);
    chk("t1_run_cycles", n_run, 4);
    chk("t1_ui0", ui_log[0], 8'hE1);
    chk("t1_ui1", ui_log[1], 8'h70);
    chk("t1_ui2", ui_log[2], 8'h38);
    chk("t1_ui3", ui_log[3], 8'h9C);
    chk("t1_sig", signature, 0);
    chk("t1_cc", cycle_count, 4);
    chk("t1_done_rst_n", bus.dut_rst_n, 1);
    chk("t1_done_ena", bus.dut_ena, 1);
    chk("t1_done_ui", bus.dut_ui, 0);

    // uo tied to 1
    bus.dut_uo = 8'h01;
    run_obs(16'd3, 16'h1234, -1);
    chk("t2_done_dropped", first_done, 0);
    chk("t2_sig_len3", signature, 32'h00000007);
    chk("t2_cc_len3", cycle_count, 3);
    run_obs(16'd33, 16'h5555, -1);
    chk("t2_sig_len33", signature, 32'hFB3EE248);
    chk("t2_cc_len33", cycle_count, 33);

    // uio pins driven by the DUT read back 0
    bus.dut_uo     = 8'h00;
    bus.dut_uio_oe = 8'hF0;
    run_obs(16'd2, 16'hACE1, -1);
    chk("t3_uio0", uio_log[0], 8'h0C);
    chk("t3_uio1", uio_log[1], 8'h02);
    bus.dut_uio_oe = 8'h00;

    // Abort in RUN, simultaneous start ignored
    bus.dut_uo = 8'h01;
    len        = 16'd10;
    seed       = 16'h0007;
    start      = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy && bus.dut_rst_n && cycle_count == 16'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_reached_cc2", found, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_rst_n", bus.dut_rst_n, 0);
    chk("t4_ena", bus.dut_ena, 0);
    chk("t4_cc", cycle_count, 2);
    chk("t4_sig", signature, 32'h00000003);
    tick();
    chk("t4_stay_idle", busy, 0);
    chk("t4_cc_hold", cycle_count, 2);
    run_obs(16'd3, 16'h0007, -1);
    chk("t4_restart_sig", signature, 32'h00000007);

    // len 0 with a start pulse during RESET
    run_obs(16'd0, 16'h0000, 1);
    chk("t5_rst_cycles", n_rst, 4);
    chk("t5_run_cycles", n_run, 0);
    chk("t5_sig", signature, 0);
    chk("t5_cc", cycle_count, 0);

    // Asynchronous reset mid-run, then a clean rerun
    len   = 16'd33;
    seed  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy && bus.dut_rst_n && cycle_count == 16'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_reached_cc5", found, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_n", bus.dut_rst_n, 0);
    chk("t6_ena", bus.dut_ena, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sig", signature, 0);
    chk("t6_cc", cycle_count, 0);
    chk("t6_ui", bus.dut_ui, 0);
    tick();
    rst = 1'b0;
    tick();
    run_obs(16'd33, 16'h0000, -1);
    chk("t6_rerun_sig", signature, 32'hFB3EE248);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
